host_bus_bridge: RTL and testbench



---
 rtl/hbb_pkg.sv | 20 ++
 rtl/hbb_fifo.sv | 51 +++++
 rtl/host_bus_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_host_bus_bridge.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hbb_pkg.sv
// Shared types and default parameters for the host bus bridge.
package hbb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_STALL = 3'd1,
        RD_DRAIN = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RD_HOLD  = 3'd5
    } hbb_state_e;

    localparam int unsigned HBB_EXT_AW     = 4;
    localparam int unsigned HBB_EXT_DW     = 8;
    localparam int unsigned HBB_INT_DW     = 16;
    localparam int unsigned HBB_FIFO_DEPTH = 4;
    localparam int unsigned HBB_N_TGT      = 2;
    localparam int unsigned HBB_RD_TIMEOUT = 255;

endpackage

// File: rtl/hbb_fifo.sv
// Posted-write FIFO; pointers carry one extra wrap bit to tell full from empty.
module hbb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/host_bus_bridge.sv
// Bridges an asynchronous 8-bit strobed host bus onto a 16-bit internal command/response port.
module host_bus_bridge
    import hbb_pkg::*;
#(
    parameter int unsigned EXT_AW     = HBB_EXT_AW,
    parameter int unsigned EXT_DW     = HBB_EXT_DW,
    parameter int unsigned INT_DW     = HBB_INT_DW,
    parameter int unsigned FIFO_DEPTH = HBB_FIFO_DEPTH,
    parameter int unsigned N_TGT      = HBB_N_TGT,
    parameter int unsigned RD_TIMEOUT = HBB_RD_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    nrd,
    input  logic                    nwr,
    input  logic                    ncs,
    input  logic [EXT_AW-1:0]       ext_address,
    input  logic [EXT_DW-1:0]       ext_data_in,
    output logic [EXT_DW-1:0]       ext_data_out,
    output logic                    ext_oe,
    output logic                    wait_sig,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic                    cmd_write,
    output logic [EXT_AW-2:0]       cmd_addr,
    output logic [INT_DW-1:0]       cmd_data,
    input  logic [N_TGT-1:0]        rsp_valid,
    input  logic [N_TGT*INT_DW-1:0] rsp_data,
    output logic                    err,
    input  logic                    err_clr
);

    localparam int unsigned CAW = EXT_AW - 1;
    localparam int unsigned PW  = CAW + INT_DW;
    localparam int unsigned CW  = $clog2(RD_TIMEOUT + 1);

    // Strobe synchronisers, bit order {nrd, nwr, ncs}; idle high.
    logic [2:0] meta_q, sync_q;
    logic       nrd_s, nwr_s, ncs_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= {nrd, nwr, ncs};
            sync_q <= meta_q;
        end
    end

    assign {nrd_s, nwr_s, ncs_s} = sync_q;
    assign ext_oe = ~ncs_s & ~nrd_s;

    logic wr_act_d, wr_act_q, rd_act_d, rd_act_q;
    logic start_wr, start_rd;

    assign wr_act_d = ~(ncs_s | nwr_s);
    assign rd_act_d = ~(ncs_s | nrd_s);
    assign start_wr = wr_act_d & ~wr_act_q;
    assign start_rd = rd_act_d & ~rd_act_q & ~start_wr;

    hbb_state_e        state_q, state_d;
    logic [EXT_DW-1:0] lo_q, lo_d, hi_q, hi_d, dout_q, dout_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CAW-1:0]    rd_addr_q, rd_addr_d;
    logic [PW-1:0]     pend_q, pend_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [PW-1:0] fifo_wdata, fifo_head, wr_payload;
    logic          rd_issue;

    // Lowest-index response wins: scan from the top so lower indices overwrite.
    logic              rsp_hit;
    logic [INT_DW-1:0] rsp_word;

    always_comb begin
        rsp_hit  = 1'b0;
        rsp_word = '0;
        for (int i = int'(N_TGT) - 1; i >= 0; i--) begin
            if (rsp_valid[i]) begin
                rsp_hit  = 1'b1;
                rsp_word = rsp_data[i*INT_DW +: INT_DW];
            end
        end
    end

    assign wr_payload = PW'({ext_address[EXT_AW-1:1], ext_data_in, lo_q});

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        dout_d     = dout_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        pend_d     = pend_q;
        fifo_push  = 1'b0;
        fifo_wdata = wr_payload;

        if (err_clr) err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_wr) begin
                    if (!ext_address[0]) begin
                        lo_d = ext_data_in;
                    end else if (!fifo_full) begin
                        fifo_push = 1'b1;
                    end else begin
                        pend_d  = wr_payload;
                        state_d = WR_STALL;
                    end
                end else if (start_rd) begin
                    if (ext_address[0]) begin
                        dout_d  = hi_q;
                        state_d = RD_HOLD;
                    end else begin
                        rd_addr_d = ext_address[EXT_AW-1:1];
                        state_d   = RD_DRAIN;
                    end
                end
            end
            WR_STALL: begin
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = pend_q;
                    state_d    = IDLE;
                end
            end
            RD_DRAIN: begin
                if (fifo_empty) state_d = RD_ISSUE;
            end
            RD_ISSUE: begin
                if (cmd_ready) begin
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rsp_hit) begin
                    dout_d  = rsp_word[EXT_DW-1:0];
                    hi_d    = rsp_word[2*EXT_DW-1:EXT_DW];
                    state_d = RD_HOLD;
                end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
                    dout_d  = '1;
                    hi_d    = '1;
                    err_d   = 1'b1;
                    state_d = RD_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_HOLD: begin
                if (nrd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            dout_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            pend_q    <= '0;
            wr_act_q  <= 1'b0;
            rd_act_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            pend_q    <= pend_d;
            wr_act_q  <= wr_act_d;
            rd_act_q  <= rd_act_d;
        end
    end

    hbb_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Reads only issue once the FIFO has drained, so the port is never contended.
    assign rd_issue  = (state_q == RD_ISSUE);
    assign cmd_valid = rd_issue | ~fifo_empty;
    assign cmd_write = ~rd_issue;
    assign cmd_addr  = rd_issue ? rd_addr_q : fifo_head[PW-1:INT_DW];
    assign cmd_data  = rd_issue ? '0 : fifo_head[INT_DW-1:0];
    assign fifo_pop  = ~rd_issue & ~fifo_empty & cmd_ready;

    assign wait_sig     = (state_q == WR_STALL) || (state_q == RD_DRAIN) ||
                          (state_q == RD_ISSUE) || (state_q == RD_WAIT);
    assign ext_data_out = dout_q;
    assign err          = err_q;

endmodule

// File: tb/tb_host_bus_bridge.sv
// Directed self-checking bench for host_bus_bridge with default parameters.
module tb_host_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nrd = 1'b1, nwr = 1'b1, ncs = 1'b1;
    logic [3:0]  ext_address = '0;
    logic [7:0]  ext_data_in = '0;
    logic [7:0]  ext_data_out;
    logic        ext_oe, wait_sig;
    logic        cmd_valid, cmd_write;
    logic        cmd_ready = 1'b0;
    logic [2:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [1:0]  rsp_valid = '0;
    logic [31:0] rsp_data = {16'h1111, 16'hBEEF};
    logic        err;
    logic        err_clr = 1'b0;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct packed {
        logic        w;
        logic [2:0]  a;
        logic [15:0] d;
    } cmd_t;

    cmd_t cmd_q[$];

    host_bus_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .nrd          (nrd),
        .nwr          (nwr),
        .ncs          (ncs),
        .ext_address  (ext_address),
        .ext_data_in  (ext_data_in),
        .ext_data_out (ext_data_out),
        .ext_oe       (ext_oe),
        .wait_sig     (wait_sig),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .err          (err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Log every handshake that will complete on the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (cmd_valid && cmd_ready && !rst) cmd_q.push_back({cmd_write, cmd_addr, cmd_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t qget(input int i);
        if (i < cmd_q.size()) return cmd_q[i];
        return '1;
    endfunction

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
        int n;
        @(negedge clk);
        ext_address = a;
        ext_data_in = d;
        ncs = 1'b0;
        nwr = 1'b0;
        repeat (3) @(negedge clk);
        n = 0;
        while (wait_sig && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 1000) chk("wr_wait_bound", 32'(n), 32'd0);
        ncs = 1'b1;
        nwr = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic host_rd(input logic [3:0] a, output logic [7:0] d, output int w);
        @(negedge clk);
        ext_address = a;
        ncs = 1'b0;
        nrd = 1'b0;
        repeat (3) @(negedge clk);
        w = 0;
        while (wait_sig && w < 2000) begin
            w++;
            @(negedge clk);
        end
        if (w >= 2000) chk("rd_wait_bound", 32'(w), 32'd0);
        d = ext_data_out;
        ncs = 1'b1;
        nrd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Answer the next read command three cycles after it is accepted.
    task automatic respond(input logic [1:0] v);
        int n;
        n = 0;
        while (!(cmd_valid && !cmd_write && cmd_ready) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) chk("rsp_cmd_bound", 32'(n), 32'd0);
        repeat (3) @(negedge clk);
        rsp_valid = v;
        @(negedge clk);
        rsp_valid = '0;
    endtask

    initial begin
        logic [7:0] d;
        int         w;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait", 32'(wait_sig), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_dout", 32'(ext_data_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_oe", 32'(ext_oe), 32'd0);

        // Byte pair assembles one word command.
        cmd_ready = 1'b1;
        host_wr(4'h2, 8'h34);
        chk("lo_byte_no_cmd", 32'(cmd_q.size()), 32'd0);
        host_wr(4'h3, 8'h12);
        chk("word_cmd_count", 32'(cmd_q.size()), 32'd1);
        chk("word_cmd", 32'(qget(0)), 32'({1'b1, 3'd1, 16'h1234}));

        // Fill the FIFO with the port stalled; the fifth word must stall the host.
        cmd_q.delete();
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            host_wr(4'(2 * i), 8'(8'h50 + i));
            host_wr(4'(2 * i + 1), 8'(8'hA0 + i));
        end
        host_wr(4'h8, 8'h54);
        fork
            host_wr(4'h9, 8'hA4);
            begin
                repeat (8) @(negedge clk);
                chk("full_stall_wait", 32'(wait_sig), 32'd1);
                chk("full_no_pop", 32'(cmd_q.size()), 32'd0);
                cmd_ready = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        chk("fifo_count", 32'(cmd_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("fifo_order", 32'(qget(i)), 32'({1'b1, 3'(i), 8'(8'hA0 + i), 8'(8'h50 + i)}));
        chk("post_stall_wait", 32'(wait_sig), 32'd0);

        // Both targets respond together; target 0 wins.
        cmd_q.delete();
        fork
            host_rd(4'h4, d, w);
            respond(2'b11);
        join
        chk("rd_lo_byte", 32'(d), 32'hEF);
        chk("rd_cmd", 32'(qget(0)), 32'({1'b0, 3'd2, 16'h0000}));
        cmd_q.delete();
        host_rd(4'h5, d, w);
        chk("rd_hi_byte", 32'(d), 32'hBE);
        chk("rd_hi_no_wait", 32'(w), 32'd0);
        chk("rd_hi_no_cmd", 32'(cmd_q.size()), 32'd0);
        chk("rd_ok_err", 32'(err), 32'd0);

        // No response: 1 drain + 1 issue + 255 wait cycles of wait_sig.
        host_rd(4'h6, d, w);
        chk("to_wait_cycles", 32'(w), 32'd257);
        chk("to_data", 32'(d), 32'hFF);
        chk("to_err_set", 32'(err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // A posted write must leave before the read that follows it.
        cmd_q.delete();
        cmd_ready = 1'b0;
        host_wr(4'h8, 8'h78);
        host_wr(4'h9, 8'h56);
        fork
            host_rd(4'hA, d, w);
            begin
                repeat (8) @(negedge clk);
                chk("drain_wait", 32'(wait_sig), 32'd1);
                chk("drain_no_cmd", 32'(cmd_q.size()), 32'd0);
                cmd_ready = 1'b1;
                respond(2'b10);
            end
        join
        chk("order_data", 32'(d), 32'h11);
        chk("order_count", 32'(cmd_q.size()), 32'd2);
        chk("order_wr_first", 32'(qget(0)), 32'({1'b1, 3'd4, 16'h5678}));
        chk("order_rd_second", 32'(qget(1)), 32'({1'b0, 3'd5, 16'h0000}));

        // Reset in the middle of a read wait.
        @(negedge clk);
        ext_address = 4'h6;
        ncs = 1'b0;
        nrd = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_rst_wait", 32'(wait_sig), 32'd1);
        chk("pre_rst_oe", 32'(ext_oe), 32'd1);
        rst = 1'b1;
        ncs = 1'b1;
        nrd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_wait", 32'(wait_sig), 32'd0);
        chk("rst_mid_valid", 32'(cmd_valid), 32'd0);
        chk("rst_mid_dout", 32'(ext_data_out), 32'd0);

        // Reset discards a queued write.
        cmd_q.delete();
        cmd_ready = 1'b0;
        host_wr(4'h2, 8'h99);
        host_wr(4'h3, 8'h88);
        chk("queued_valid", 32'(cmd_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_flush_valid", 32'(cmd_valid), 32'd0);
        cmd_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_flush_nocmd", 32'(cmd_q.size()), 32'd0);

        // Latches come out of reset cleared.
        host_rd(4'h1, d, w);
        chk("rst_hi_latch", 32'(d), 32'h00);
        host_wr(4'h3, 8'h77);
        repeat (3) @(negedge clk);
        chk("rst_lo_latch", 32'(qget(0)), 32'({1'b1, 3'd1, 16'h7700}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
